// File: rtl/ram_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_if
//  Description : Bundle of the two requester handshakes and the RAM macro bus
//                around ram_arb.
//                slave  : arbiter view (requests in, acks/read data out).
//                master : environment view (requesters and RAM macro).
//  Ports       : a_* / b_* requester handshake, ram_* RAM bus, busy status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    input  ram_rdata,
    output a_ack, a_rvalid, a_rdata,
    output b_ack, b_rvalid, b_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    output ram_rdata,
    input  a_ack, a_rvalid, a_rdata,
    input  b_ack, b_rvalid, b_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb
//  Description : Round-robin arbiter sharing one single-port synchronous RAM
//                between requester A (UART) and requester B (panel), with
//                bounded burst locking and read-data steering after RD_LAT.
//  Ports       : clk       - system clock (rising edge)
//                rst       - synchronous active-high reset
//                arb_io    - ram_arb_if.slave: both requester handshakes,
//                            RAM bus (en/we/addr/wdata/rdata) and busy
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arb #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ram_arb_if.slave   arb_io
);

  localparam int                CNT_W       = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  C_MAX       = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0]  C_ONE       = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] C_DATA_ZERO = '0;

  // Arbitration state
  logic             prio_q,     prio_d;      // 0 = A favoured, 1 = B
  logic             owner_q,    owner_d;     // last granted requester
  logic             lock_act_q, lock_act_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Read return pipeline: stage 0 is loaded in the issue cycle, stage
  // RD_LAT-1 is the one whose data is on ram_rdata.
  logic [RD_LAT-1:0] pipe_v_q,  pipe_v_d;
  logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;

  logic w_gnt_a, w_gnt_b, w_gnt, w_gnt_id;
  logic w_owner_req, w_other_req;
  logic w_ret_a, w_ret_b;

  assign w_owner_req = owner_q ? arb_io.b_req : arb_io.a_req;
  assign w_other_req = owner_q ? arb_io.a_req : arb_io.b_req;

  // Grant selection; suppressed entirely during reset.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst) begin
      if (lock_act_q && w_owner_req && (!w_other_req || lock_cnt_q < C_MAX)) begin
        w_gnt_a = ~owner_q;
        w_gnt_b = owner_q;
      end else if (arb_io.a_req && arb_io.b_req) begin
        w_gnt_a = ~prio_q;
        w_gnt_b = prio_q;
      end else if (arb_io.a_req) begin
        w_gnt_a = 1'b1;
      end else if (arb_io.b_req) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  assign w_gnt    = w_gnt_a | w_gnt_b;
  assign w_gnt_id = w_gnt_b;

  assign arb_io.a_ack     = w_gnt_a;
  assign arb_io.b_ack     = w_gnt_b;
  assign arb_io.ram_en    = w_gnt;
  assign arb_io.ram_we    = w_gnt_a ? arb_io.a_we    : (w_gnt_b ? arb_io.b_we    : 1'b0);
  assign arb_io.ram_addr  = w_gnt_a ? arb_io.a_addr  : (w_gnt_b ? arb_io.b_addr  : C_ADDR_ZERO);
  assign arb_io.ram_wdata = w_gnt_a ? arb_io.a_wdata : (w_gnt_b ? arb_io.b_wdata : C_DATA_ZERO);

  // Next-state for arbitration and read pipeline
  always_comb begin
    prio_d     = prio_q;
    owner_d    = owner_q;
    lock_act_d = lock_act_q;
    lock_cnt_d = lock_cnt_q;
    if (w_gnt) begin
      prio_d     = ~w_gnt_id;
      owner_d    = w_gnt_id;
      lock_act_d = w_gnt_id ? arb_io.b_lock : arb_io.a_lock;
      // Re-grant of a locked owner extends the burst; saturates so a lone
      // locked requester can keep the bus indefinitely.
      if (lock_act_q && (owner_q == w_gnt_id)) begin
        lock_cnt_d = (lock_cnt_q == C_MAX) ? C_MAX : lock_cnt_q + C_ONE;
      end else begin
        lock_cnt_d = C_ONE;
      end
    end else if (!w_owner_req) begin
      lock_act_d = 1'b0;
    end

    pipe_v_d     = pipe_v_q;
    pipe_id_d    = pipe_id_q;
    pipe_v_d[0]  = w_gnt & ~arb_io.ram_we;
    pipe_id_d[0] = w_gnt_id;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1];
      pipe_id_d[i] = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      lock_act_q <= 1'b0;
      lock_cnt_q <= '0;
      pipe_v_q   <= '0;
      pipe_id_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      lock_act_q <= lock_act_d;
      lock_cnt_q <= lock_cnt_d;
      pipe_v_q   <= pipe_v_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  // Read return steering; masked during reset so a discarded read never
  // surfaces in the reset cycle itself.
  assign w_ret_a = pipe_v_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1] & ~rst;
  assign w_ret_b = pipe_v_q[RD_LAT-1] &  pipe_id_q[RD_LAT-1] & ~rst;

  assign arb_io.a_rvalid = w_ret_a;
  assign arb_io.b_rvalid = w_ret_b;
  assign arb_io.a_rdata  = w_ret_a ? arb_io.ram_rdata : C_DATA_ZERO;
  assign arb_io.b_rdata  = w_ret_b ? arb_io.ram_rdata : C_DATA_ZERO;
  assign arb_io.busy     = (|pipe_v_q) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arb
//  Description : Bench for ram_arb. Two DUTs (RD_LAT=1 and RD_LAT=3) share
//                identical stimulus; each has its own RAM macro model. A
//                rule-level model predicts grants, RAM bus and read returns
//                every cycle; directed sequences pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arb;

  localparam int MAX_LOCK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_req = 0, a_we = 0, a_lock = 0;
  logic [7:0] a_addr = 0, a_wdata = 0;
  logic       b_req = 0, b_we = 0, b_lock = 0;
  logic [7:0] b_addr = 0, b_wdata = 0;

  ram_arb_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
  ram_arb_if #(.ADDR_W(8), .DATA_W(8)) if3 ();

  assign if1.a_req = a_req;   assign if3.a_req = a_req;
  assign if1.a_we = a_we;     assign if3.a_we = a_we;
  assign if1.a_lock = a_lock; assign if3.a_lock = a_lock;
  assign if1.a_addr = a_addr; assign if3.a_addr = a_addr;
  assign if1.a_wdata = a_wdata; assign if3.a_wdata = a_wdata;
  assign if1.b_req = b_req;   assign if3.b_req = b_req;
  assign if1.b_we = b_we;     assign if3.b_we = b_we;
  assign if1.b_lock = b_lock; assign if3.b_lock = b_lock;
  assign if1.b_addr = b_addr; assign if3.b_addr = b_addr;
  assign if1.b_wdata = b_wdata; assign if3.b_wdata = b_wdata;

  ram_arb #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .MAX_LOCK(MAX_LOCK)) u_dut1 (
    .clk(clk), .rst(rst), .arb_io(if1)
  );
  ram_arb #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .MAX_LOCK(MAX_LOCK)) u_dut3 (
    .clk(clk), .rst(rst), .arb_io(if3)
  );

  // RAM macro models: data appears exactly RD_LAT cycles after the strobe.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] sh1;
  logic [7:0] sh3 [3];
  assign if1.ram_rdata = sh1;
  assign if3.ram_rdata = sh3[2];

  always @(posedge clk) begin
    if (if1.ram_en && if1.ram_we) mem1[if1.ram_addr] <= if1.ram_wdata;
    if (if3.ram_en && if3.ram_we) mem3[if3.ram_addr] <= if3.ram_wdata;
    sh1    <= (if1.ram_en && !if1.ram_we) ? mem1[if1.ram_addr] : 8'h00;
    sh3[0] <= (if3.ram_en && !if3.ram_we) ? mem3[if3.ram_addr] : 8'h00;
    sh3[1] <= sh3[0];
    sh3[2] <= sh3[1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [256];
  int  m_prio = 0, m_owner = 0, m_run = 0;
  bit  m_locked = 0;
  int  cyc = 0;
  logic [8:0] p1 [int];   // return cycle -> {id, data}
  logic [8:0] p3 [int];

  task automatic chk_ret(input string nm, input logic av, input logic [7:0] ad,
                         input logic bv, input logic [7:0] bd, input bit has, input logic [8:0] e);
    logic ea, eb;
    ea = has && !e[8];
    eb = has &&  e[8];
    chk({nm, "_a_rvalid"}, 32'(av), 32'(ea));
    chk({nm, "_b_rvalid"}, 32'(bv), 32'(eb));
    chk({nm, "_a_rdata"},  32'(ad), ea ? 32'(e[7:0]) : 32'h0);
    chk({nm, "_b_rdata"},  32'(bd), eb ? 32'(e[7:0]) : 32'h0);
  endtask

  always @(negedge clk) begin : p_model
    int win;
    bit hold, bz1, bz3, h1, h3;
    bit [1:0] rq, lk;
    logic ewe;
    logic [7:0] ea, ed;
    logic [8:0] e1, e3;

    rq  = {b_req, a_req};
    lk  = {b_lock, a_lock};
    win = -1;
    if (rst) begin
      m_prio = 0; m_owner = 0; m_run = 0; m_locked = 0;
      p1.delete(); p3.delete();
    end else begin
      hold = m_locked && rq[m_owner] && (!rq[1-m_owner] || m_run < MAX_LOCK);
      if (hold)            win = m_owner;
      else if (rq == 2'b11) win = m_prio;
      else if (rq[0])      win = 0;
      else if (rq[1])      win = 1;
    end
    ewe = (win == 0) ? a_we    : (win == 1) ? b_we    : 1'b0;
    ea  = (win == 0) ? a_addr  : (win == 1) ? b_addr  : 8'h00;
    ed  = (win == 0) ? a_wdata : (win == 1) ? b_wdata : 8'h00;

    chk("l1_a_ack", 32'(if1.a_ack), 32'(win == 0));
    chk("l1_b_ack", 32'(if1.b_ack), 32'(win == 1));
    chk("l3_a_ack", 32'(if3.a_ack), 32'(win == 0));
    chk("l3_b_ack", 32'(if3.b_ack), 32'(win == 1));
    chk("l1_ram_en", 32'(if1.ram_en), 32'(win >= 0));
    chk("l3_ram_en", 32'(if3.ram_en), 32'(win >= 0));
    chk("l1_ram_we", 32'(if1.ram_we), 32'(ewe));
    chk("l1_ram_addr", 32'(if1.ram_addr), 32'(ea));
    chk("l1_ram_wdata", 32'(if1.ram_wdata), 32'(ed));
    chk("l3_ram_addr", 32'(if3.ram_addr), 32'(ea));

    // A read is in flight from the cycle after issue through its return cycle.
    bz1 = 0; bz3 = 0;
    foreach (p1[r]) if (r - 1 < cyc) bz1 = 1;
    foreach (p3[r]) if (r - 3 < cyc) bz3 = 1;
    chk("l1_busy", 32'(if1.busy), 32'(bz1));
    chk("l3_busy", 32'(if3.busy), 32'(bz3));

    h1 = p1.exists(cyc); e1 = 9'h0;
    if (h1) begin e1 = p1[cyc]; p1.delete(cyc); end
    h3 = p3.exists(cyc); e3 = 9'h0;
    if (h3) begin e3 = p3[cyc]; p3.delete(cyc); end
    chk_ret("l1", if1.a_rvalid, if1.a_rdata, if1.b_rvalid, if1.b_rdata, h1, e1);
    chk_ret("l3", if3.a_rvalid, if3.a_rdata, if3.b_rvalid, if3.b_rdata, h3, e3);

    if (win >= 0) begin
      if (m_locked && m_owner == win) m_run = (m_run < MAX_LOCK) ? m_run + 1 : MAX_LOCK;
      else                            m_run = 1;
      m_prio   = 1 - win;
      m_owner  = win;
      m_locked = lk[win];
      if (ewe) m_mem[ea] = ed;
      else begin
        p1[cyc + 1] = {win[0], m_mem[ea]};
        p3[cyc + 3] = {win[0], m_mem[ea]};
      end
    end else if (!rst && !rq[m_owner]) begin
      m_locked = 0;
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); step(); step(); rst = 0;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    logic [15:0] sa, sb;
    int busy_cnt, rv_cnt;
    for (int i = 0; i < 256; i++) begin
      mem1[i] <= 8'h00; mem3[i] <= 8'h00; m_mem[i] = 8'h00;
    end
    mem1[1] <= 8'h11; mem3[1] <= 8'h11; m_mem[1] = 8'h11;
    mem1[2] <= 8'h22; mem3[2] <= 8'h22; m_mem[2] = 8'h22;
    mem1[3] <= 8'h33; mem3[3] <= 8'h33; m_mem[3] = 8'h33;
    rst = 1;
    step(); step();
    @(negedge clk);
    chk("rst_busy", 32'(if3.busy), 32'h0);
    chk("rst_a_ack", 32'(if1.a_ack), 32'h0);
    step();
    rst = 0;

    // 1: write 0x5A @0x10 then read back, RD_LAT=1
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
    @(negedge clk);
    chk("t1_wr_ack", 32'(if1.a_ack), 32'h1);
    chk("t1_wr_en", 32'(if1.ram_en), 32'h1);
    chk("t1_wr_we", 32'(if1.ram_we), 32'h1);
    step();
    a_we = 0; a_wdata = 8'h00;
    @(negedge clk);
    chk("t1_rd_ack", 32'(if1.a_ack), 32'h1);
    step();
    idle();
    @(negedge clk);
    chk("t1_a_rvalid", 32'(if1.a_rvalid), 32'h1);
    chk("t1_a_rdata", 32'(if1.a_rdata), 32'h5A);
    chk("t1_b_rvalid", 32'(if1.b_rvalid), 32'h0);
    step(); step(); step(); step();

    // 2: both requesting, no lock -> strict alternation
    do_reset();
    a_req = 1; a_we = 1; a_addr = 8'h80; b_req = 1; b_we = 1; b_addr = 8'h90;
    sa = 0; sb = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sa = {sa[14:0], if1.a_ack}; sb = {sb[14:0], if1.b_ack};
      step();
    end
    chk("t2_a_order", 32'(sa), 32'h2A);   // 101010
    chk("t2_b_order", 32'(sb), 32'h15);   // 010101

    // 3: A locked burst against waiting B
    do_reset();
    a_req = 1; a_we = 1; a_lock = 1; a_addr = 8'h81; b_req = 1; b_we = 1; b_addr = 8'h91;
    sa = 0; sb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sa = {sa[14:0], if1.a_ack}; sb = {sb[14:0], if1.b_ack};
      step();
    end
    chk("t3_a_order", 32'(sa), 32'h3FD);  // 1111111101
    chk("t3_b_order", 32'(sb), 32'h002);  // 0000000010

    // 3b: lone locked requester keeps the grant; counter saturated -> B next
    do_reset();
    a_req = 1; a_we = 1; a_lock = 1; a_addr = 8'h82;
    sa = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sa = {sa[14:0], if1.a_ack};
      step();
    end
    chk("t3b_a_held", 32'(sa), 32'hFFF);
    b_req = 1; b_we = 1; b_addr = 8'h92;
    @(negedge clk);
    chk("t3b_b_wins", 32'(if1.b_ack), 32'h1);
    step();
    idle();

    // 4: back-to-back reads, RD_LAT=3
    do_reset();
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k == 0) begin a_req = 1; a_addr = 8'h01; end
      if (k == 1) begin b_req = 1; b_addr = 8'h02; end
      if (k == 2) begin a_req = 1; a_addr = 8'h03; end
      @(negedge clk);
      busy_cnt += int'(if3.busy);
      if (k == 3) begin
        chk("t4_k3_a_rvalid", 32'(if3.a_rvalid), 32'h1);
        chk("t4_k3_a_rdata", 32'(if3.a_rdata), 32'h11);
      end
      if (k == 4) begin
        chk("t4_k4_b_rvalid", 32'(if3.b_rvalid), 32'h1);
        chk("t4_k4_b_rdata", 32'(if3.b_rdata), 32'h22);
      end
      if (k == 5) begin
        chk("t4_k5_a_rvalid", 32'(if3.a_rvalid), 32'h1);
        chk("t4_k5_a_rdata", 32'(if3.a_rdata), 32'h33);
      end
      step();
    end
    chk("t4_busy_cycles", 32'(busy_cnt), 32'd5);

    // 5: reset while a read is in flight
    do_reset();
    rv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      rst = (k == 1);
      if (k == 0) begin a_req = 1; a_addr = 8'h02; end
      @(negedge clk);
      if (k >= 1) begin
        rv_cnt += int'(if3.a_rvalid) + int'(if3.b_rvalid) + int'(if1.a_rvalid) + int'(if1.b_rvalid);
        chk("t5_busy", 32'(if3.busy), 32'h0);
      end
      step();
    end
    chk("t5_no_rvalid", 32'(rv_cnt), 32'h0);
    a_req = 1; a_we = 1; a_addr = 8'h84; b_req = 1; b_we = 1; b_addr = 8'h94;
    @(negedge clk);
    chk("t5_prio_a", 32'(if1.a_ack), 32'h1);
    step();

    // 6: no requester, stale address/data on the inputs
    idle();
    a_addr = 8'h33; a_wdata = 8'h77; b_addr = 8'h44; b_wdata = 8'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_ram_en", 32'(if1.ram_en), 32'h0);
      chk("t6_ram_addr", 32'(if1.ram_addr), 32'h0);
      chk("t6_ram_wdata", 32'(if1.ram_wdata), 32'h0);
      chk("t6_acks", 32'({if1.a_ack, if1.b_ack}), 32'h0);
      step();
    end
    // Priority unchanged by idle cycles: B is still favoured
    a_req = 1; a_we = 1; b_req = 1; b_we = 1;
    @(negedge clk);
    chk("t6_prio_b", 32'(if1.b_ack), 32'h1);
    step();
    idle();
    step(); step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
